booth_prod_accum: RTL and testbench

//  Downstream stage of the unsigned Booth multiplier. Takes its 2N-bit products over a

---
 rtl/booth_prod_accum.sv | 166 ++++++++++++++++
 tb/tb_booth_prod_accum.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/booth_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : booth_prod_accum
// Purpose  : Accumulates the unsigned 2N-bit products of the Booth multiplier
//            over valid/ready bursts. Each burst ends on in_last. The stage
//            then presents the burst sum, the beat count and a sticky
//            overflow flag on a valid/ready result handshake.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid/in_ready   - product stream handshake
//            in_prod [2N-1:0]    - unsigned product
//            in_last             - final beat of the burst
//            out_valid/out_ready - result handshake
//            out_acc [ACC_W-1:0] - burst sum modulo 2^ACC_W
//            out_count [CNT_W-1:0] - beats in burst, saturating
//            out_ovf             - some add in the burst carried out
//            busy                - burst in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
module booth_prod_accum #(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf,
    output logic               busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    // Zero-extension width taking the product up to the ACC_W+1 carry width.
    localparam int c_pad = ACC_W + 1 - 2 * N;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_release;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_prod_ext;
    logic [CNT_W-1:0] w_count_inc;

    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ovf_nxt;

    // in_ready depends on state only, so upstream can never form a
    // combinational loop through in_valid.
    assign in_ready   = (r_state != c_st_hold);
    assign out_valid  = (r_state == c_st_hold);
    assign busy       = (r_state != c_st_idle);

    assign w_accept   = in_valid && in_ready;
    assign w_release  = out_valid && out_ready;

    assign w_prod_ext = {{(c_pad-1){1'b0}}, in_prod};
    // Top bit of w_sum is the carry out of the accumulator width.
    assign w_sum      = {1'b0, r_acc} + {{c_pad{1'b0}}, in_prod};

    // Counter sticks at all-ones rather than wrapping.
    assign w_count_inc = (r_count == c_cnt_max) ? c_cnt_max : (r_count + c_cnt_one);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    // First beat loads rather than adds, so a burst never
                    // inherits residue from the previous one.
                    w_acc_nxt   = w_prod_ext;
                    w_count_nxt = c_cnt_one;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = in_last ? c_st_hold : c_st_accum;
                end
            end

            c_st_accum: begin
                // Cycles without in_valid are gaps: everything holds.
                if (w_accept) begin
                    w_acc_nxt   = w_sum[ACC_W-1:0];
                    w_ovf_nxt   = r_ovf | w_sum[ACC_W];
                    w_count_nxt = w_count_inc;
                    if (in_last) begin
                        w_state_nxt = c_st_hold;
                    end
                end
            end

            c_st_hold: begin
                // in_ready is low here, so the release cycle is a bubble.
                if (w_release) begin
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle stage.
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_ovf_nxt   = 1'b0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Result outputs come straight from registers and only change on the
    // release handshake while in HOLD, so they are stable for the consumer.
    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_booth_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_prod_accum
// Purpose  : Directed self-checking bench for booth_prod_accum with
//            hand-computed expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_prod_accum;

    localparam int N     = 4;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2*N-1:0]     in_prod;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic [CNT_W-1:0]   out_count;
    logic               out_ovf;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    booth_prod_accum #(
        .N     (N),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one cycle (in_ready is known high here).
    task automatic send_beat(input logic [2*N-1:0] prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    // Result must be visible immediately after the last beat's edge.
    task automatic take_result(input string tag, input int e_acc, input int e_cnt, input int e_ovf);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_acc"},   {16'd0, out_acc},   e_acc);
        check({tag, "_cnt"},   {24'd0, out_count}, e_cnt);
        check({tag, "_ovf"},   {31'd0, out_ovf},   e_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd1);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_ovf",   {31'd0, out_ovf},   32'd0);

        // 2: three beats of 225 with an idle gap inside the burst
        send_beat(8'd225, 1'b0);
        check("b3_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check("b3_gap_valid", {31'd0, out_valid}, 32'd0);
        send_beat(8'd225, 1'b0);
        send_beat(8'd225, 1'b1);
        take_result("b3", 675, 3, 0);

        // 3: single-beat burst from IDLE
        send_beat(8'd42, 1'b1);
        take_result("single", 42, 1, 0);

        // 4: 292 beats of 225 -> wraps once and saturates the counter
        for (int i = 0; i < 292; i++) begin
            send_beat(8'd225, (i == 291) ? 1'b1 : 1'b0);
        end
        take_result("long", 164, 255, 1);

        // 5: backpressure in HOLD; an offered beat must be ignored
        send_beat(8'd100, 1'b0);
        send_beat(8'd50, 1'b1);
        in_valid = 1'b1;
        in_prod  = 8'd77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready},  32'd0);
            check("bp_acc",   {16'd0, out_acc},   32'd150);
            check("bp_cnt",   {24'd0, out_count}, 32'd2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result("bp", 150, 2, 0);
        check("bp_after_valid", {31'd0, out_valid}, 32'd0);
        send_beat(8'd10, 1'b1);
        take_result("bp_next", 10, 1, 0);

        // 6: reset mid-burst discards everything
        send_beat(8'd200, 1'b0);
        send_beat(8'd200, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",  {31'd0, busy},      32'd0);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_ready", {31'd0, in_ready},  32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_post_valid", {31'd0, out_valid}, 32'd0);
        send_beat(8'd7, 1'b0);
        send_beat(8'd8, 1'b1);
        take_result("mrst", 15, 2, 0);

        // Exhaustive single-beat A*B products for 4-bit operands
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send_beat(8'(a * b), 1'b1);
                check("mul_acc", {16'd0, out_acc}, a * b);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
